// File: rtl/iter_calc_pkg.sv
// ============================================================================
// Module : iter_calc_pkg
// Brief  : Shared state encodings and helpers for iterative arithmetic blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iter_calc_pkg;

    // Widest operand the helpers below can handle.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } calc_state_t;

    function automatic logic [MAX_W-1:0] width_mask(input int w);
        return (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction

    // Magnitude of a w-bit value; the most negative value maps to 2^(w-1).
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input int w, input logic sgn);
        if (sgn && (|(v & (MAX_W'(1) << (w - 1)))))
            return (~v + MAX_W'(1)) & width_mask(w);
        else
            return v & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] sat_bound(input int w, input logic sgn,
                                                   input logic hi);
        if (hi)
            return sgn ? ((MAX_W'(1) << (w - 1)) - MAX_W'(1)) : width_mask(w);
        else
            return sgn ? (MAX_W'(1) << (w - 1)) : {MAX_W{1'b0}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/iter_linear_calc_sa.sv
// ============================================================================
// Module : iter_linear_calc_sa
// Brief  : y = m*x + b via early-terminating shift-add, optional signed mode,
//          overflow flag with saturate or wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_linear_calc_sa
    import iter_calc_pkg::*;
#(
    parameter int W        = 32,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] m,
    input  logic [W-1:0] x,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         ovf
);

    localparam int   RW  = 2 * W + 2;
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);

    calc_state_t      state_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     mplier_q;
    logic [2*W-1:0]   mcand_q;
    logic [2*W-1:0]   acc_q;
    logic             neg_q;
    logic             busy_q;
    logic             valid_q;
    logic             ovf_q;
    logic [W-1:0]     y_q;

    logic [W-1:0]     m_abs;
    logic [W-1:0]     x_abs;
    logic             neg_d;
    logic [2*W-1:0]   acc_d;
    logic [RW-1:0]    acc_ext;
    logic [RW-1:0]    prod;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    res;
    logic             ovf_d;
    logic [W-1:0]     y_d;

    assign m_abs = W'(abs_w(MAX_W'(m), W, SGN));
    assign x_abs = W'(abs_w(MAX_W'(x), W, SGN));
    assign neg_d = SGN && (m[W-1] ^ x[W-1]);
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Result path is wide enough that neither -|m*x| nor adding b can wrap.
    assign acc_ext = {2'b00, acc_q};
    assign prod    = neg_q ? (~acc_ext + RW'(1)) : acc_ext;
    assign b_ext   = SGN ? {{(W + 2){b_q[W-1]}}, b_q} : {{(W + 2){1'b0}}, b_q};
    assign res     = prod + b_ext;

    always_comb begin
        if (SGN)
            ovf_d = !((&res[RW-1:W-1]) || !(|res[RW-1:W-1]));
        else
            ovf_d = |res[RW-1:W];
        y_d = res[W-1:0];
        if (ovf_d && SAT)
            y_d = (SGN && res[RW-1]) ? W'(sat_bound(W, SGN, 1'b0))
                                     : W'(sat_bound(W, SGN, 1'b1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            y_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        b_q      <= b;
                        mcand_q  <= {{W{1'b0}}, m_abs};
                        mplier_q <= x_abs;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    // Stop once no set multiplier bits remain after this shift.
                    if (mplier_q[W-1:1] == '0)
                        state_q <= S_FIN;
                end
                S_FIN: begin
                    y_q     <= y_d;
                    ovf_q   <= ovf_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign y     = y_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire
